// File: rtl/gf16_pkg.sv
// Shared constants and types for the GF(2^16) reduction stage.
// Holds the default irreducible polynomial, datapath widths and the FSM state type.
package gf16_pkg;

   localparam int GF_W   = 16;
   localparam int PROD_W = 32;

   // x^16 + x^12 + x^3 + x + 1
   localparam logic [GF_W:0] GF_POLY_DEFAULT = 17'h1100B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : gf16_pkg

// File: rtl/gf16_red_step.sv
// One combinational reduction step: clears bit idx of r by XORing the polynomial
// aligned so that its leading term lands on idx.
module gf16_red_step
   import gf16_pkg::*;
#(
   parameter logic [GF_W:0] POLY = GF_POLY_DEFAULT
) (
   input  logic [PROD_W-1:0] r,
   input  logic [4:0]        idx,
   output logic [PROD_W-1:0] r_next
);

   logic [PROD_W-1:0] poly_aligned;

   // {POLY, 15'b0} puts the x^16 term at bit 31; shifting right moves it down to idx.
   assign poly_aligned = {POLY, 15'b0} >> (5'd31 - idx);
   assign r_next       = r[idx] ? (r ^ poly_aligned) : r;

endmodule : gf16_red_step

// File: rtl/gf16_reduce.sv
// Sequential GF(2^16) reduction of a 32-bit carry-less product, valid/ready on both sides.
// Define GF_RED_2BIT_EN to retire two bits per BUSY cycle (8 cycles instead of 16).
module gf16_reduce
   import gf16_pkg::*;
#(
   parameter logic [GF_W:0] POLY = GF_POLY_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [GF_W-1:0]   out_rem,
   output logic              busy
);

   state_t            state;
   state_t            next_state;
   logic [PROD_W-1:0] r;
   logic [4:0]        idx;
   logic [PROD_W-1:0] r_s0;
   logic [PROD_W-1:0] r_step;
   logic              last_step;

   gf16_red_step #(.POLY(POLY)) u_step0 (
      .r      (r),
      .idx    (idx),
      .r_next (r_s0)
   );

`ifdef GF_RED_2BIT_EN
   localparam logic [4:0] IDX_DEC = 5'd2;
   logic [4:0] idx_lo;

   assign idx_lo = idx - 5'd1;

   // Second step sees the register value already updated by the first.
   gf16_red_step #(.POLY(POLY)) u_step1 (
      .r      (r_s0),
      .idx    (idx_lo),
      .r_next (r_step)
   );

   assign last_step = (idx == 5'd17);
`else
   localparam logic [4:0] IDX_DEC = 5'd1;

   assign r_step    = r_s0;
   assign last_step = (idx == 5'd16);
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (in_valid)  next_state = BUSY;
         BUSY:    if (last_step) next_state = DONE;
         DONE:    if (out_ready) next_state = IDLE;
         default:                next_state = IDLE;
      endcase
   end

   // Handshake outputs decode registered state only.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         BUSY:    busy      = 1'b1;
         DONE:    out_valid = 1'b1;
         default: in_ready  = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r       <= '0;
         idx     <= 5'd31;
         out_rem <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  r   <= in_prod;
                  idx <= 5'd31;
               end
            end
            BUSY: begin
               r   <= r_step;
               idx <= idx - IDX_DEC;
               if (last_step) out_rem <= r_step[GF_W-1:0];
            end
            default: ;
         endcase
      end
   end

endmodule : gf16_reduce
